// File: rtl/gpr_wb_arbiter.sv
// Writeback arbiter and pending-write scoreboard for the 8 x 16-bit GPR file.
// Optional commit-cycle read bypass is enabled by defining GPR_WB_BYPASS_EN.
module gpr_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              reserve_en,
  input  logic [ADDR_W-1:0] reserve_dest,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0] reg_write_data,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  input  logic [DATA_W-1:0] gpr_rd_data_1,
  input  logic [DATA_W-1:0] gpr_rd_data_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              hazard_1,
  output logic              hazard_2,
  output logic [NREG-1:0]   busy_vec,
  output logic              err_waw
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  src_e              prio_q, prio_d;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_dest_q, wr_dest_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              err_q, err_d;
  logic              grant;

  // A lone requester always wins; on contention the favoured source wins.
  assign alu_ready = alu_valid && (!mem_valid || (prio_q == SRC_ALU));
  assign mem_ready = mem_valid && (!alu_valid || (prio_q == SRC_MEM));
  assign grant     = alu_ready || mem_ready;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    prio_d    = prio_q;
    wr_dest_d = wr_dest_q;
    wr_data_d = wr_data_q;
    if (alu_ready) begin
      prio_d    = SRC_MEM;
      wr_dest_d = alu_dest;
      wr_data_d = alu_data;
    end else if (mem_ready) begin
      prio_d    = SRC_ALU;
      wr_dest_d = mem_dest;
      wr_data_d = mem_data;
    end
  end

  // Clear for the committing write first, so a same-cycle reservation wins.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (wr_en_q) busy_d[wr_dest_q] = 1'b0;
    if (reserve_en) begin
      busy_d[reserve_dest] = 1'b1;
      if (busy_q[reserve_dest]) err_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q    <= SRC_ALU;
      wr_en_q   <= 1'b0;
      wr_dest_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      wr_en_q   <= grant;
      wr_dest_q <= wr_dest_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign reg_write_en   = wr_en_q;
  assign reg_write_dest = wr_dest_q;
  assign reg_write_data = wr_data_q;
  assign busy_vec       = busy_q;
  assign err_waw        = err_q;

  always_comb begin
    rd_data_1 = gpr_rd_data_1;
    rd_data_2 = gpr_rd_data_2;
    hazard_1  = busy_q[rd_addr_1];
    hazard_2  = busy_q[rd_addr_2];
`ifdef GPR_WB_BYPASS_EN
    // Forward the committing write so the reader avoids a one-cycle stall.
    if (wr_en_q && (rd_addr_1 == wr_dest_q)) begin
      rd_data_1 = wr_data_q;
      hazard_1  = 1'b0;
    end
    if (wr_en_q && (rd_addr_2 == wr_dest_q)) begin
      rd_data_2 = wr_data_q;
      hazard_2  = 1'b0;
    end
`endif
  end

endmodule
